// File: rtl/shreg_op_sequencer.sv
// Command sequencer for one universal shift register: turns clear / shift-by-N / load
// commands into cycle-by-cycle s0/s1/mr/g1/g2 control and reports completion.
module shreg_op_sequencer #(
    parameter int CNT_W   = 4,
    parameter int CLR_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    input  logic             oe_en,
    output logic             s0,
    output logic             s1,
    output logic             mr,
    output logic             g1,
    output logic             g2,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] cnt_rem
);

    localparam int CLR_W = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LOAD, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [CLR_W-1:0]  clr_rem, clr_n;
    logic              left, left_n;
    logic              aborted_n;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and inputs are ignored while it is low.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_rem;
        clr_n     = clr_rem;
        left_n    = left;
        aborted_n = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        2'b00: begin
                            state_n = CLEAR;
                            clr_n   = CLR_W'(CLR_CYC);
                        end
                        2'b01, 2'b10: begin
                            left_n  = cmd_op[1];
                            cnt_n   = cmd_cnt;
                            state_n = (cmd_cnt == '0) ? DONE : SHIFT;
                        end
                        default: state_n = LOAD;
                    endcase
                end
            end
            CLEAR: begin
                clr_n = clr_rem - CLR_W'(1);
                if (clr_rem == CLR_W'(1)) begin
                    state_n = DONE;
                end else if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end
            end
            SHIFT: begin
                // The current cycle's shift edge is issued even when aborting,
                // so the count left in DONE excludes it.
                cnt_n = cnt_rem - CNT_W'(1);
                if (cnt_rem == CNT_W'(1)) begin
                    state_n = DONE;
                end else if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end
            end
            LOAD: state_n = DONE;
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_rem   <= '0;
            clr_rem   <= '0;
            left      <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            mr        <= 1'b1;
            g1        <= 1'b1;
            g2        <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt_rem   <= cnt_n;
            clr_rem   <= clr_n;
            left      <= left_n;
            s0        <= (state_n == LOAD) || ((state_n == SHIFT) && left_n);
            s1        <= (state_n == LOAD) || ((state_n == SHIFT) && !left_n);
            mr        <= (state_n != CLEAR);
            // I/O pins are inputs during a load, so the enables are forced off.
            g1        <= (state_n == LOAD) || !oe_en;
            g2        <= (state_n == LOAD) || !oe_en;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n == CLEAR) || (state_n == SHIFT) || (state_n == LOAD);
            done      <= (state_n == DONE);
            aborted   <= aborted_n;
        end
    end

endmodule

// File: doc/shreg_op_sequencer.md
Name: shreg_op_sequencer

Overview:
Command-driven sequencer for the universal shift register, one instance per register. Accepts clear, shift-right-by-N, shift-left-by-N and parallel-load commands over a valid/ready handshake. Sequences the register control lines (s0/s1 mode select, mr clear, g1/g2 output enables) cycle by cycle and reports completion. It sits between the system control logic and the shift-register datapath.

Parameters:
CNT_W, 4, width of shift-count field; max shift per command 2^CNT_W-1.
CLR_CYC, 2, number of cycles mr is held low for a clear command; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  2  00 clear, 01 shift right, 10 shift left, 11 parallel load.
cmd_cnt  input  CNT_W  shift count; used only for ops 01/10.
abort  input  1  terminates an in-progress clear or shift.
oe_en  input  1  requests register outputs enabled when not loading.
s0  output  1  mode select bit 0 to the register.
s1  output  1  mode select bit 1 to the register.
mr  output  1  master reset to the register, active low.
g1  output  1  output enable 1, active low.
g2  output  1  output enable 2, active low.
busy  output  1  command in progress.
done  output  1  one-cycle completion pulse.
aborted  output  1  qualifies done; high when the command was cut short.
cnt_rem  output  CNT_W  shift cycles still to be issued.

Behaviour:
Decided interface: one clock (clk); reset is asynchronous and active-low (rst_n).

All outputs are registered. The (s0,s1) encoding is 00 hold, 01 right, 10 left, 11 load.

Reset (rst_n low, asynchronous):
- state IDLE.
- s0=0, s1=0, mr=1.
- g1=1, g2=1 (outputs disabled).
- cmd_ready=1.
- busy=0, done=0, aborted=0, cnt_rem=0.

Reset mid-command: the command is dropped immediately and outputs take their reset values. No done pulse is produced.

States: IDLE, CLEAR, SHIFT, LOAD, DONE.

IDLE:
- cmd_ready=1, s0s1=00, mr=1.
- Handshake: a command is accepted at a rising edge where cmd_valid and cmd_ready are both high. At that same edge cmd_ready falls and busy rises.
- cmd_op, cmd_cnt and the mode bits are captured at that edge. Changes to cmd inputs while not ready are ignored.

CLEAR:
- mr=0, s0s1=00 for exactly CLR_CYC cycles, counted with an internal counter.
- Then DONE, with mr returning to 1 in the DONE cycle.

SHIFT:
- s0s1=01 (right) or 10 (left) for exactly cmd_cnt cycles.
- cnt_rem loads cmd_cnt and decrements once per shift cycle; it reads 0 in DONE.
- cmd_cnt=0: SHIFT is skipped, going IDLE -> DONE directly with s0s1=00. No shift edge is issued and aborted=0.

LOAD:
- s0s1=11 for exactly one cycle.
- g1=g2=1 is forced for that cycle regardless of oe_en, because the I/O pins act as inputs during a load.
- Then DONE.

DONE:
- One cycle: s0s1=00, mr=1, done=1, busy=0, cmd_ready=0.
- Next state IDLE, with cmd_ready=1 the following cycle.

Latency:
- Accept edge T0; control lines are active from T1.
- done occurs at T(n+1), where n is cmd_cnt (shift), CLR_CYC (clear) or 1 (load).
- The next command can be accepted at the edge ending T(n+2).

Output enables:
- g1=g2=~oe_en, sampled each cycle, in every state except LOAD.

Abort:
- Sampled in CLEAR or SHIFT. The next cycle is DONE with s0s1=00, mr=1, done=1 and aborted=1.
- cnt_rem holds the unissued count in DONE.
- abort in IDLE, LOAD or DONE is ignored; aborted stays 0.
- If abort coincides with the final shift or clear cycle, the command completes normally (aborted=0).

Test Plan:
1. Reset release -> s0s1=00, mr=1, g1=g2=1, cmd_ready=1, busy=0. Then with oe_en=1 -> g1=g2=0 one cycle later.
2. Shift right, cmd_cnt=5 -> s0s1=01 for exactly 5 cycles (cnt_rem 5,4,3,2,1), then done=1 with aborted=0, then cmd_ready=1 on the following cycle.
3. Parallel load with oe_en=1 -> one cycle of s0s1=11 with g1=g2=1, then done. g1=g2 return to 0 in the DONE cycle.
4. Clear, CLR_CYC=2 -> mr=0 for 2 cycles, then done. A second command (shift left, cnt=0) held on cmd_valid throughout is not accepted until cmd_ready=1; it then gives done one cycle after acceptance with zero shift cycles.
5. Shift left cnt=10 with abort pulsed in the 4th shift cycle -> 4 cycles of s0s1=10, then DONE with aborted=1 and cnt_rem=6. A separate run with abort during LOAD is ignored.
6. rst_n asserted mid-shift (cnt=8, third cycle) -> all outputs at reset values asynchronously and no done pulse. After release, a new command is accepted normally.
